// File: rtl/phy_link_monitor.sv
// phy_link_monitor
//   Management sequencer in front of a clause-22 MDIO controller. After reset
//   it waits INIT_DELAY cycles, writes BMCR_INIT to the PHY control register,
//   then every POLL_INTERVAL cycles reads BMSR twice and the PHY-specific
//   status register. It publishes link/speed/duplex to the MAC. Between polls
//   it serves one host register access at a time.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   mdio_read / mdio_write   : one-cycle request pulses to the controller
//   mdio_phy_address         : constant PHY_ADDRESS
//   mdio_reg_address         : register address, held from request to completion
//   mdio_write_data          : write data, held from request to completion
//   mdio_read_data           : controller read result (valid with complete)
//   mdio_access_complete     : one-cycle completion pulse from the controller
//   mdio_busy                : controller has a request pending
//   host_req/we/reg/wdata    : level host request and its attributes
//   host_rdata / host_ack    : host read result and one-cycle completion pulse
//   link_up/speed/full_duplex: resolved link state (changes only after a poll)
//   an_complete              : BMSR bit 5 from the latest poll
//   status_valid             : set after the first completed poll
//   mdio_error               : sticky access-timeout flag
module phy_link_monitor #(
   parameter int                        PHYADDR_LENGTH = 5,
   parameter int                        REGADDR_LENGTH = 5,
   parameter int                        DATA_LENGTH    = 16,
   parameter logic [PHYADDR_LENGTH-1:0] PHY_ADDRESS    = 5'd1,
   parameter logic [REGADDR_LENGTH-1:0] STATUS_REG     = 5'd17,
   parameter logic [DATA_LENGTH-1:0]    BMCR_INIT      = 16'h1340,
   parameter int                        INIT_DELAY     = 125000,
   parameter int                        POLL_INTERVAL  = 1250000,
   parameter int                        ACCESS_TIMEOUT = 8192
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      mdio_read,
   output logic                      mdio_write,
   output logic [PHYADDR_LENGTH-1:0] mdio_phy_address,
   output logic [REGADDR_LENGTH-1:0] mdio_reg_address,
   output logic [DATA_LENGTH-1:0]    mdio_write_data,
   input  logic [DATA_LENGTH-1:0]    mdio_read_data,
   input  logic                      mdio_access_complete,
   input  logic                      mdio_busy,
   input  logic                      host_req,
   input  logic                      host_we,
   input  logic [REGADDR_LENGTH-1:0] host_reg,
   input  logic [DATA_LENGTH-1:0]    host_wdata,
   output logic [DATA_LENGTH-1:0]    host_rdata,
   output logic                      host_ack,
   output logic                      link_up,
   output logic [1:0]                speed,
   output logic                      full_duplex,
   output logic                      an_complete,
   output logic                      status_valid,
   output logic                      mdio_error
);

   localparam int DLY_W  = $clog2(INIT_DELAY + 1);
   localparam int POLL_W = $clog2(POLL_INTERVAL + 1);
   localparam int TO_W   = $clog2(ACCESS_TIMEOUT + 1);
   localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(INIT_DELAY - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACCESS_TIMEOUT - 1);
   localparam logic [REGADDR_LENGTH-1:0] REG_BMCR = '0;
   localparam logic [REGADDR_LENGTH-1:0] REG_BMSR = REGADDR_LENGTH'(1);

   typedef enum logic [2:0] {
      S_INIT_WAIT, S_INIT_WR, S_IDLE_WAIT, S_HOST_ACC,
      S_RD_BMSR1, S_RD_BMSR2, S_RD_PHYSTS, S_UPDATE
   } state_t;

   state_t                    r_state;
   logic                      r_issued;      // request sent, waiting for completion
   logic [TO_W-1:0]           r_to_cnt;
   logic [DLY_W-1:0]          r_dly_cnt;
   logic [POLL_W-1:0]         r_poll_cnt;
   logic                      r_poll_due;
   logic                      r_host_we;
   logic [REGADDR_LENGTH-1:0] r_host_reg;
   logic [DATA_LENGTH-1:0]    r_host_wdata;
   logic [DATA_LENGTH-1:0]    r_rd_data;     // last captured read data
   logic                      r_bmsr_link;
   logic                      r_bmsr_an;
   logic [1:0]                r_phy_spd;
   logic                      r_phy_dup;
   logic                      r_phy_res;

   logic                      w_acc_active;
   logic                      w_acc_write;
   logic [REGADDR_LENGTH-1:0] w_acc_addr;
   logic [DATA_LENGTH-1:0]    w_acc_wdata;
   logic                      w_acc_timeout;
   logic                      w_acc_done;
   logic [DATA_LENGTH-1:0]    w_acc_rdata;
   logic                      w_poll_wrap;
   logic                      w_host_take;
   logic                      w_poll_take;
   logic                      w_init_done;

   assign mdio_phy_address = PHY_ADDRESS;

   always_comb begin
      w_acc_active = 1'b1;
      w_acc_write  = 1'b0;
      w_acc_addr   = REG_BMCR;
      w_acc_wdata  = mdio_write_data;
      case (r_state)
         S_INIT_WR: begin
            w_acc_write = 1'b1;
            w_acc_wdata = BMCR_INIT;
         end
         S_HOST_ACC: begin
            w_acc_write = r_host_we;
            w_acc_addr  = r_host_reg;
            w_acc_wdata = r_host_wdata;
         end
         S_RD_BMSR1, S_RD_BMSR2: w_acc_addr = REG_BMSR;
         S_RD_PHYSTS:            w_acc_addr = STATUS_REG;
         default:                w_acc_active = 1'b0;
      endcase
   end

   // Completion is only the controller's pulse or our own timeout; a falling
   // busy is deliberately ignored.
   assign w_acc_timeout = r_issued && !mdio_access_complete && (r_to_cnt == TO_LAST);
   assign w_acc_done    = r_issued && (mdio_access_complete || (r_to_cnt == TO_LAST));
   assign w_acc_rdata   = mdio_access_complete ? mdio_read_data : '1;

   assign w_poll_wrap = (r_poll_cnt == POLL_LAST);
   assign w_init_done = (r_state == S_INIT_WR) && w_acc_done;
   // A host request still high during its own ack cycle is not taken again.
   assign w_host_take = (r_state == S_IDLE_WAIT) && host_req && !host_ack;
   assign w_poll_take = (r_state == S_IDLE_WAIT) && !w_host_take && r_poll_due;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_INIT_WAIT;
         r_issued         <= 1'b0;
         r_to_cnt         <= '0;
         r_dly_cnt        <= '0;
         r_poll_cnt       <= '0;
         r_poll_due       <= 1'b0;
         r_host_we        <= 1'b0;
         r_host_reg       <= '0;
         r_host_wdata     <= '0;
         r_rd_data        <= '0;
         r_bmsr_link      <= 1'b0;
         r_bmsr_an        <= 1'b0;
         r_phy_spd        <= 2'b00;
         r_phy_dup        <= 1'b0;
         r_phy_res        <= 1'b0;
         mdio_read        <= 1'b0;
         mdio_write       <= 1'b0;
         mdio_reg_address <= '0;
         mdio_write_data  <= '0;
         host_rdata       <= '0;
         host_ack         <= 1'b0;
         link_up          <= 1'b0;
         speed            <= 2'b00;
         full_duplex      <= 1'b0;
         an_complete      <= 1'b0;
         status_valid     <= 1'b0;
         mdio_error       <= 1'b0;
      end else begin
         mdio_read  <= 1'b0;
         mdio_write <= 1'b0;
         host_ack   <= 1'b0;

         // Free-running poll timer; restarted when the BMCR write finishes so
         // the first poll lands one full interval later. A wrap during a poll
         // leaves a single pending request.
         if (w_init_done) begin
            r_poll_cnt <= '0;
            r_poll_due <= 1'b0;
         end else begin
            r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
            if (w_poll_wrap)
               r_poll_due <= 1'b1;
            else if (w_poll_take)
               r_poll_due <= 1'b0;
         end

         // Shared access primitive: issue when the controller is free, then
         // hold address/data until completion or timeout.
         if (w_acc_active) begin
            if (!r_issued) begin
               if (!mdio_busy) begin
                  mdio_read        <= !w_acc_write;
                  mdio_write       <= w_acc_write;
                  mdio_reg_address <= w_acc_addr;
                  mdio_write_data  <= w_acc_wdata;
                  r_issued         <= 1'b1;
                  r_to_cnt         <= '0;
               end
            end else if (w_acc_done) begin
               r_issued <= 1'b0;
               if (w_acc_timeout)
                  mdio_error <= 1'b1;
               if (!w_acc_write)
                  r_rd_data <= w_acc_rdata;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end

         case (r_state)
            S_INIT_WAIT: begin
               if (r_dly_cnt == DLY_LAST)
                  r_state <= S_INIT_WR;
               else
                  r_dly_cnt <= r_dly_cnt + 1'b1;
            end
            S_INIT_WR: begin
               if (w_acc_done)
                  r_state <= S_IDLE_WAIT;
            end
            S_IDLE_WAIT: begin
               if (w_host_take) begin
                  r_host_we    <= host_we;
                  r_host_reg   <= host_reg;
                  r_host_wdata <= host_wdata;
                  r_state      <= S_HOST_ACC;
               end else if (w_poll_take) begin
                  r_state <= S_RD_BMSR1;
               end
            end
            S_HOST_ACC: begin
               if (w_acc_done) begin
                  host_ack   <= 1'b1;
                  host_rdata <= r_host_we ? r_rd_data : w_acc_rdata;
                  r_state    <= S_IDLE_WAIT;
               end
            end
            S_RD_BMSR1: begin
               // First read only clears the latched-low link bit.
               if (w_acc_done)
                  r_state <= S_RD_BMSR2;
            end
            S_RD_BMSR2: begin
               if (w_acc_done) begin
                  r_bmsr_link <= w_acc_rdata[2];
                  r_bmsr_an   <= w_acc_rdata[5];
                  r_state     <= S_RD_PHYSTS;
               end
            end
            S_RD_PHYSTS: begin
               if (w_acc_done) begin
                  r_phy_spd <= w_acc_rdata[15:14];
                  r_phy_dup <= w_acc_rdata[13];
                  r_phy_res <= w_acc_rdata[11];
                  r_state   <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               an_complete  <= r_bmsr_an;
               status_valid <= 1'b1;
               // Speed code 11 is reserved (also what a timed-out read yields).
               if (r_bmsr_link && r_phy_res && (r_phy_spd != 2'b11)) begin
                  link_up     <= 1'b1;
                  speed       <= r_phy_spd;
                  full_duplex <= r_phy_dup;
               end else begin
                  link_up     <= 1'b0;
                  speed       <= 2'b00;
                  full_duplex <= 1'b0;
               end
               r_state <= S_IDLE_WAIT;
            end
            default: r_state <= S_INIT_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_phy_link_monitor.sv
module tb_phy_link_monitor;

   localparam int P  = 400;
   localparam int TO = 100;
   localparam int ID = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mdio_read, mdio_write;
   logic [4:0]  mdio_phy_address, mdio_reg_address;
   logic [15:0] mdio_write_data;
   logic [15:0] mdio_read_data = 16'h0;
   logic        mdio_access_complete = 1'b0;
   logic        mdio_busy = 1'b0;
   logic        host_req = 1'b0;
   logic        host_we = 1'b0;
   logic [4:0]  host_reg = 5'd0;
   logic [15:0] host_wdata = 16'h0;
   logic [15:0] host_rdata;
   logic        host_ack, link_up, full_duplex, an_complete, status_valid, mdio_error;
   logic [1:0]  speed;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int c_init = 0;
   logic [15:0] last_rd = 16'h0;
   // reference model of the published status
   logic       m_link = 1'b0;
   logic [1:0] m_speed = 2'b00;
   logic       m_fd = 1'b0;
   logic       m_an = 1'b0;
   logic       m_valid = 1'b0;

   phy_link_monitor #(
      .INIT_DELAY    (ID),
      .POLL_INTERVAL (P),
      .ACCESS_TIMEOUT(TO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .mdio_read           (mdio_read),
      .mdio_write          (mdio_write),
      .mdio_phy_address    (mdio_phy_address),
      .mdio_reg_address    (mdio_reg_address),
      .mdio_write_data     (mdio_write_data),
      .mdio_read_data      (mdio_read_data),
      .mdio_access_complete(mdio_access_complete),
      .mdio_busy           (mdio_busy),
      .host_req            (host_req),
      .host_we             (host_we),
      .host_reg            (host_reg),
      .host_wdata          (host_wdata),
      .host_rdata          (host_rdata),
      .host_ack            (host_ack),
      .link_up             (link_up),
      .speed               (speed),
      .full_duplex         (full_duplex),
      .an_complete         (an_complete),
      .status_valid        (status_valid),
      .mdio_error          (mdio_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int lat();
      return $urandom_range(1, 4);
   endfunction

   // Link resolution rules applied to the second BMSR read and PHYSTS.
   function automatic void predict(input logic [15:0] bmsr, input logic [15:0] physts,
                                   output logic l, output logic [1:0] s,
                                   output logic f, output logic a);
      a = bmsr[5];
      l = bmsr[2] && physts[11] && (physts[15:14] != 2'b11);
      s = l ? physts[15:14] : 2'b00;
      f = l ? physts[13] : 1'b0;
   endfunction

   task automatic expect_req(input string tag, input logic wr, input logic [4:0] addr,
                             input logic [15:0] wdata, input int budget);
      int n = 0;
      while (!(mdio_read || mdio_write) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'(mdio_read || mdio_write), 32'd1);
      check({tag, "_kind"}, 32'({mdio_write, mdio_read}), wr ? 32'd2 : 32'd1);
      check({tag, "_addr"}, 32'(mdio_reg_address), 32'(addr));
      if (wr) check({tag, "_wdata"}, 32'(mdio_write_data), 32'(wdata));
   endtask

   // Controller model: busy for lt cycles, busy low one cycle, then complete.
   task automatic serve(input logic [15:0] rdata, input int lt);
      int extra = 0;
      int moved = 0;
      logic [4:0]  a0 = mdio_reg_address;
      logic [15:0] d0 = mdio_write_data;
      mdio_busy = 1'b1;
      repeat (lt) begin
         tick();
         if (mdio_read || mdio_write) extra++;
         if (mdio_reg_address !== a0 || mdio_write_data !== d0) moved++;
      end
      mdio_busy = 1'b0;
      tick();
      if (mdio_read || mdio_write) extra++;
      mdio_access_complete = 1'b1;
      mdio_read_data = rdata;
      tick();
      if (mdio_read || mdio_write) extra++;
      mdio_access_complete = 1'b0;
      mdio_read_data = 16'($urandom);
      check("no_req_during_access", 32'(extra), 32'd0);
      check("addr_data_stable", 32'(moved), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_rd"},     32'(mdio_read), 32'd0);
      check({tag, "_wr"},     32'(mdio_write), 32'd0);
      check({tag, "_ack"},    32'(host_ack), 32'd0);
      check({tag, "_addr"},   32'(mdio_reg_address), 32'd0);
      check({tag, "_wdata"},  32'(mdio_write_data), 32'd0);
      check({tag, "_rdata"},  32'(host_rdata), 32'd0);
      check({tag, "_link"},   32'(link_up), 32'd0);
      check({tag, "_speed"},  32'(speed), 32'd0);
      check({tag, "_fd"},     32'(full_duplex), 32'd0);
      check({tag, "_an"},     32'(an_complete), 32'd0);
      check({tag, "_valid"},  32'(status_valid), 32'd0);
      check({tag, "_err"},    32'(mdio_error), 32'd0);
      check({tag, "_phyad"},  32'(mdio_phy_address), 32'd1);
   endtask

   // Reset has just been released; expect the BMCR write INIT_DELAY edges on.
   task automatic do_init(input string tag);
      int n = 0;
      int acks = 0;
      while (n < ID + 20) begin
         tick();
         if (host_ack) acks++;
         if (mdio_read || mdio_write) break;
         n++;
      end
      check({tag, "_cycle"}, 32'(n), 32'(ID));
      check({tag, "_kind"},  32'({mdio_write, mdio_read}), 32'd2);
      check({tag, "_addr"},  32'(mdio_reg_address), 32'd0);
      check({tag, "_wdata"}, 32'(mdio_write_data), 32'h1340);
      check({tag, "_noack"}, 32'(acks), 32'd0);
      serve(16'($urandom), lat());
      c_init = cyc;
   endtask

   task automatic run_poll(input string tag, input logic [15:0] b1, input logic [15:0] b2,
                           input logic [15:0] ps, input int budget, input int start_at);
      logic l, f, a;
      logic [1:0] s;
      expect_req({tag, "_bmsr1"}, 1'b0, 5'd1, 16'h0, budget);
      if (start_at >= 0) check({tag, "_start"}, 32'(cyc), 32'(start_at));
      serve(b1, lat());
      expect_req({tag, "_bmsr2"}, 1'b0, 5'd1, 16'h0, 8);
      serve(b2, lat());
      expect_req({tag, "_physts"}, 1'b0, 5'd17, 16'h0, 8);
      serve(ps, lat());
      last_rd = ps;
      check({tag, "_hold_link"},  32'(link_up), 32'(m_link));
      check({tag, "_hold_speed"}, 32'(speed), 32'(m_speed));
      tick();
      predict(b2, ps, l, s, f, a);
      m_link = l; m_speed = s; m_fd = f; m_an = a; m_valid = 1'b1;
      check({tag, "_link"},  32'(link_up), 32'(m_link));
      check({tag, "_speed"}, 32'(speed), 32'(m_speed));
      check({tag, "_fd"},    32'(full_duplex), 32'(m_fd));
      check({tag, "_an"},    32'(an_complete), 32'(m_an));
      check({tag, "_valid"}, 32'(status_valid), 32'(m_valid));
   endtask

   initial begin
      logic [15:0] b1, b2, ps, hw;
      logic [4:0]  hr;
      logic        l, f, a;
      logic [1:0]  s;
      int          w;

      // reset values
      reset = 1'b1;
      repeat (3) tick();
      chk_reset("reset");
      reset = 1'b0;

      // init write, then the first poll one full interval after it finishes
      do_init("init");
      run_poll("poll1", 16'h0000, 16'h796D, 16'hAC00, P + 50, c_init + P + 2);
      check("poll1_link_const",  32'(link_up), 32'd1);
      check("poll1_speed_const", 32'(speed), 32'd2);
      check("poll1_fd_const",    32'(full_duplex), 32'd1);

      // reserved speed code forces link down
      run_poll("e800", 16'h0000, 16'h796D, 16'hE800, P + 50, -1);
      check("e800_link_const",  32'(link_up), 32'd0);
      check("e800_speed_const", 32'(speed), 32'd0);

      // randomized polls
      for (int k = 0; k < 6; k++) begin
         b1 = 16'($urandom);
         b2 = 16'($urandom);
         ps = 16'($urandom);
         b2[2]  = ($urandom_range(0, 3) != 0);
         ps[11] = ($urandom_range(0, 3) != 0);
         run_poll("rnd", b1, b2, ps, P + 50, -1);
      end

      // host read raised in the very cycle the poll flag sets: host goes first
      w = c_init + ((cyc - c_init) / P + 1) * P;
      while (cyc < w) tick();
      host_req = 1'b1; host_we = 1'b0; host_reg = 5'd2;
      expect_req("host_rd", 1'b0, 5'd2, 16'h0, 8);
      check("host_rd_start", 32'(cyc), 32'(w + 2));
      serve(16'h0141, lat());
      last_rd = 16'h0141;
      check("host_rd_ack",   32'(host_ack), 32'd1);
      check("host_rd_rdata", 32'(host_rdata), 32'h0141);
      tick();
      check("host_rd_ack_pulse", 32'(host_ack), 32'd0);
      host_req = 1'b0;
      run_poll("after_host", 16'h0000, 16'h796D, 16'hAC00, 4, -1);

      // host write returns the last captured read data
      hw = 16'($urandom);
      hr = 5'($urandom);
      host_req = 1'b1; host_we = 1'b1; host_reg = hr; host_wdata = hw;
      expect_req("host_wr", 1'b1, hr, hw, 8);
      serve(16'($urandom), lat());
      check("host_wr_ack",   32'(host_ack), 32'd1);
      check("host_wr_rdata", 32'(host_rdata), 32'(last_rd));
      host_req = 1'b0;
      tick();
      check("host_wr_ack_pulse", 32'(host_ack), 32'd0);

      // silent controller: host read times out, then a whole poll times out
      host_req = 1'b1; host_we = 1'b0; host_reg = 5'd3;
      expect_req("host_to", 1'b0, 5'd3, 16'h0, 8);
      repeat (TO - 1) tick();
      check("to_err_early", 32'(mdio_error), 32'd0);
      check("to_ack_early", 32'(host_ack), 32'd0);
      tick();
      check("to_err",   32'(mdio_error), 32'd1);
      check("to_ack",   32'(host_ack), 32'd1);
      check("to_rdata", 32'(host_rdata), 32'hFFFF);
      host_req = 1'b0;
      expect_req("to_bmsr1", 1'b0, 5'd1, 16'h0, P + 50);
      repeat (TO) tick();
      expect_req("to_bmsr2", 1'b0, 5'd1, 16'h0, 8);
      repeat (TO) tick();
      expect_req("to_physts", 1'b0, 5'd17, 16'h0, 8);
      repeat (TO) tick();
      check("to_hold_link", 32'(link_up), 32'(m_link));
      tick();
      predict(16'hFFFF, 16'hFFFF, l, s, f, a);
      m_link = l; m_speed = s; m_fd = f; m_an = a;
      check("to_poll_link",  32'(link_up), 32'(m_link));
      check("to_poll_speed", 32'(speed), 32'(m_speed));
      check("to_poll_fd",    32'(full_duplex), 32'(m_fd));
      check("to_poll_an",    32'(an_complete), 32'(m_an));
      check("to_poll_valid", 32'(status_valid), 32'd1);

      // normal poll again; error stays sticky
      run_poll("recover", 16'h0000, 16'h796D, 16'hAC00, P + 50, -1);
      check("err_sticky", 32'(mdio_error), 32'd1);

      // reset while the PHYSTS read is outstanding
      expect_req("rst_bmsr1", 1'b0, 5'd1, 16'h0, P + 50);
      serve(16'h0000, lat());
      expect_req("rst_bmsr2", 1'b0, 5'd1, 16'h0, 8);
      serve(16'h796D, lat());
      expect_req("rst_physts", 1'b0, 5'd17, 16'h0, 8);
      mdio_busy = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      mdio_busy = 1'b0;
      chk_reset("midreset");
      reset = 1'b0;
      do_init("reinit");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/phy_link_monitor.md
Name: phy_link_monitor

Overview:
- Management sequencer directly upstream of the clause-22 MDIO controller; sole owner of the controller's request port.
- After reset, writes the PHY control register once, then periodically polls BMSR and the PHY-specific status register.
- Publishes link, speed and duplex to the tri-mode MAC speed-select logic.
- Provides a single-outstanding host register access port that is served between polls.

Parameters:
- PHYADDR_LENGTH, 5, width of the PHY address field
- REGADDR_LENGTH, 5, width of the register address field
- DATA_LENGTH, 16, width of register data
- PHY_ADDRESS, 5'd1, PHY address used for every access
- STATUS_REG, 5'd17, PHY-specific status register address
- BMCR_INIT, 16'h1340, value written to reg 0 after reset (AN enable, AN restart, full duplex, 1000M)
- INIT_DELAY, 125000, clk cycles waited after reset before the BMCR write
- POLL_INTERVAL, 1250000, clk cycles from one poll start to the next (10 ms at 125 MHz)
- ACCESS_TIMEOUT, 8192, clk cycles allowed per access before it is abandoned

Ports:
- clk  in  1  system clock (gmii clock domain, same as MDIO controller)
- reset  in  1  synchronous, active-high reset
- mdio_read  out  1  one-cycle read request to the controller
- mdio_write  out  1  one-cycle write request to the controller
- mdio_phy_address  out  PHYADDR_LENGTH  always PHY_ADDRESS
- mdio_reg_address  out  REGADDR_LENGTH  register address; stable from request until completion
- mdio_write_data  out  DATA_LENGTH  write data; stable from request until completion
- mdio_read_data  in  DATA_LENGTH  controller read result; valid when mdio_access_complete=1
- mdio_access_complete  in  1  one-cycle completion pulse from the controller
- mdio_busy  in  1  controller request pending
- host_req  in  1  level host request; held high until host_ack
- host_we  in  1  1 = write, 0 = read; sampled when the request is accepted
- host_reg  in  REGADDR_LENGTH  host register address
- host_wdata  in  DATA_LENGTH  host write data
- host_rdata  out  DATA_LENGTH  host read result; valid with host_ack
- host_ack  out  1  one-cycle completion pulse for a host access
- link_up  out  1  resolved link status
- speed  out  2  00 = 10M, 01 = 100M, 10 = 1000M
- full_duplex  out  1  resolved duplex
- an_complete  out  1  BMSR bit 5 from the latest poll
- status_valid  out  1  set after the first completed poll; held until reset
- mdio_error  out  1  sticky; set on any access timeout

Behaviour:
- Reset values:
  - mdio_read, mdio_write, host_ack: 0
  - mdio_reg_address, mdio_write_data, host_rdata: 0
  - link_up, full_duplex, an_complete, status_valid, mdio_error: 0
  - speed: 00
  - FSM state: INIT_WAIT; poll timer and delay counter: 0
- Reset mid-access abandons the access with no ack.
- Access primitive (used by every state below):
  - ISSUE: when mdio_busy==0, pulse mdio_read or mdio_write for exactly 1 cycle, with address and data already driven.
  - WAIT: hold address and data until mdio_access_complete; capture mdio_read_data on that cycle.
  - The next request is issued no earlier than the cycle after the access_complete pulse. A falling mdio_busy is never used as the completion signal, because the controller drops busy before it returns to IDLE.
  - Timeout: ACCESS_TIMEOUT cycles in WAIT without completion sets mdio_error and treats the access as complete with read data 16'hFFFF.
- FSM:
  - INIT_WAIT: count to INIT_DELAY-1, then go to INIT_WR.
  - INIT_WR: write BMCR_INIT to reg 0, then go to IDLE_WAIT. The poll timer is cleared so the first poll starts POLL_INTERVAL cycles later.
  - IDLE_WAIT: the poll timer runs in every state, counting 0..POLL_INTERVAL-1 and wrapping; a wrap sets poll_due.
    - If host_req is high, go to HOST_ACC.
    - Otherwise, if poll_due is set, clear it and go to RD_BMSR1.
    - If host_req and poll_due are both set, the host is served first and the poll follows immediately after.
  - HOST_ACC: one access to host_reg (write if host_we). On completion, pulse host_ack for 1 cycle with host_rdata (last captured read data on writes) and return to IDLE_WAIT. A host_req that is still high on the ack cycle is not re-accepted on that cycle.
  - RD_BMSR1: read reg 1 and discard the result (clears the latched-low link bit). Go to RD_BMSR2.
  - RD_BMSR2: read reg 1 and keep bits [2] and [5]. Go to RD_PHYSTS.
  - RD_PHYSTS: read STATUS_REG, then go to UPDATE.
  - UPDATE: one cycle; register the outputs, set status_valid, return to IDLE_WAIT.
    - an_complete = BMSR[5].
    - If BMSR[2]==1, PHYSTS[11]==1 (resolved) and PHYSTS[15:14] != 11: link_up=1, speed=PHYSTS[15:14], full_duplex=PHYSTS[13].
    - Otherwise: link_up=0, speed=00, full_duplex=0.
- A poll that ends with a timeout still runs UPDATE; the 16'hFFFF speed field 11 forces link_up=0.
- A poll_due that sets again while a poll is in progress is kept; a single pending flag, with no queueing beyond one.
- The speed, duplex and link outputs change only in UPDATE.

Test Plan:
- INIT_DELAY=10 after reset -> exactly one mdio_write pulse at cycle 10 with reg 0 and data 16'h1340; no other request until access_complete.
- Poll with BMSR reads 16'h0000 then 16'h796D, PHYSTS 16'hAC00 -> three reads in order reg 1, 1, 17; then link_up=1, speed=10, full_duplex=1, an_complete=1, status_valid=1.
- PHYSTS 16'hE800 (speed field 11) -> link_up=0, speed=00, full_duplex=0.
- host_req with host_we=0, host_reg=2 asserted on the same cycle poll_due sets -> host read of reg 2 completes with host_ack and host_rdata=16'h0141, then the poll reads start.
- Controller model never returns access_complete, ACCESS_TIMEOUT=100 -> mdio_error=1 after 100 cycles; the host read acks with 16'hFFFF and the FSM returns to IDLE_WAIT.
- Reset asserted mid-way through RD_PHYSTS -> all outputs return to reset values next cycle; no host_ack; the init sequence restarts.
